tod_clock_core: RTL and testbench
=================================

TOD_CLOCK_CORE -- requirements
Module: tod_clock_core

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 50000000, meaning input clock cycles per second (minimum 2).
REQ-002 The module SHALL have parameter ALARM_SECS, default 30, meaning alarm ring duration in seconds (1..255).
REQ-003 The module SHALL have port CLOCK_50  in  1  system clock; the only clock, all flops on its rising edge.
REQ-004 The module SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port load  in  1  one-cycle pulse; load time from load_hour/load_min/load_sec.
REQ-006 The module SHALL have ports load_hour  in  5, load_min  in  6 and load_sec  in  6, carrying binary time to load.
REQ-007 The module SHALL have port mode12  in  1  1 = 12-hour display, 0 = 24-hour display.
REQ-008 The module SHALL have port alarm_set  in  1  one-cycle pulse; latch alarm_hour/alarm_min.
REQ-009 The module SHALL have ports alarm_hour  in  5 and alarm_min  in  6, carrying binary alarm time.
REQ-010 The module SHALL have port alarm_en  in  1  alarm arm level.
REQ-011 The module SHALL have port alarm_stop  in  1  one-cycle pulse; silence the ringing alarm.
REQ-012 The module SHALL have ports hour_bcd  out  8, min_bcd  out  8 and sec_bcd  out  8, each a packed BCD {tens, units}.
REQ-013 The module SHALL have port pm  out  1  1 when the internal hour is 12..23, in both modes.
REQ-014 The module SHALL have port tick  out  1  one-cycle pulse per second.
REQ-015 The module SHALL have port alarm  out  1  alarm ringing.

Function
REQ-016 Prescaler SHALL count 0..CLK_HZ-1 and wrap; tick SHALL be 1 exactly in the cycle the prescaler equals CLK_HZ-1.
REQ-017 All time counters SHALL advance only in the cycle after tick, under CLOCK_50, with no derived clocks.
REQ-018 sec SHALL wrap 59->0 and carry to min; min SHALL wrap 59->0 and carry to hour; hour SHALL wrap 23->0. Carries SHALL be same-cycle, so 23:59:59 -> 00:00:00 in one step.
REQ-019 Internal time SHALL always be held as 24-hour binary: hour 5 bits, min 6 bits, sec 6 bits.
REQ-020 On load, each field SHALL be clamped independently: hour>23, min>59 or sec>59 SHALL load 0 for that field only.
REQ-021 On load, the prescaler SHALL be cleared to 0, so the first tick after load arrives CLK_HZ cycles later.
REQ-022 When load and an increment coincide, load SHALL win and the increment SHALL be discarded.
REQ-023 On alarm_set, alarm_hour/alarm_min SHALL be latched with the same clamp rules; alarm_set SHALL NOT change time or alarm output.
REQ-024 Ring start: alarm SHALL assert when an increment (not a load) makes time equal alarm_hour:alarm_min:00 while alarm_en=1.
REQ-025 Ring duration: alarm SHALL remain 1 for ALARM_SECS ticks, then clear.
REQ-026 Early clear: alarm_stop, or alarm_en=0, SHALL clear alarm on the next edge; each has priority over the ring start condition in the same cycle.
REQ-027 Alarm states SHALL be IDLE and RINGING: IDLE->RINGING on match, RINGING->IDLE on duration expiry, alarm_stop or !alarm_en. A new match while RINGING SHALL restart the duration count.
REQ-028 Display outputs SHALL be registered from internal time, one cycle after the counter update: two cycles after tick, and two cycles after the load pulse.
REQ-029 When mode12=1, hour_bcd SHALL show 0->12, 1..12 unchanged and 13..23 -> 1..11; when mode12=0, hour_bcd SHALL show 0..23.
REQ-030 A mode12 change SHALL take effect on the next output register update, within one cycle, without altering internal time.

Reset
REQ-031 Reset SHALL clear prescaler, time, and alarm registers, and SHALL set the alarm FSM to IDLE.
REQ-032 After reset, outputs SHALL be hour_bcd=8'h00, min_bcd=8'h00, sec_bcd=8'h00, pm=0, tick=0 and alarm=0.
REQ-033 Reset asserted mid-ring or mid-count SHALL take effect immediately and asynchronously; counting SHALL resume from prescaler 0 on release.

Structure
REQ-034 Package tod_pkg SHALL hold SEC_MAX=59, MIN_MAX=59 and HOUR_MAX=23, the BCD digit type, and the alarm state encoding.
REQ-035 Binary-to-BCD conversion SHALL be implemented as the single sub-module tod_bin2bcd (6-bit in, 8-bit BCD out), instantiated three times.
REQ-036 The prescaler and counters SHALL stay inline; no module other than tod_bin2bcd SHALL be instantiated.

Verification (CLK_HZ=4, ALARM_SECS=3)
REQ-037 Reset, then 4 cycles: tick every 4th cycle; sec_bcd=8'h01 two cycles after the first tick.
REQ-038 Load 23:59:59 then one tick: outputs 00:00:00, pm 1->0.
REQ-039 Load 25:61:30: time=00:00:30; prescaler restart verified by the next tick 4 cycles after load.
REQ-040 mode12=1 with time loaded 00:00:00 and then 13:05:00: hour_bcd=8'h12 with pm=0, then hour_bcd=8'h01 with pm=1.
REQ-041 Alarm 07:00 with alarm_en=1, load 06:59:59, one tick: alarm=1, and alarm=0 after 3 further ticks; repeating with alarm_stop at tick 1 clears alarm next cycle.
REQ-042 Load 07:00:00 with alarm set to 07:00: alarm stays 0 (load-triggered match); reset asserted while ringing: alarm=0 immediately.

Source files
------------

// File: rtl/tod_pkg.sv
// Shared constants, types and field helpers for the time-of-day clock core.
// Limits are 24-hour binary; helpers clamp loaded fields and map hours for 12-hour display.
package tod_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [0:0] {
    ALARM_IDLE    = 1'b0,
    ALARM_RINGING = 1'b1
  } alarm_state_t;

  // Out-of-range minute/second fields load as zero.
  function automatic logic [5:0] clamp_min_sec(input logic [5:0] v);
    return (v > SEC_MAX) ? 6'd0 : v;
  endfunction

  function automatic logic [4:0] clamp_hour(input logic [4:0] v);
    return (v > HOUR_MAX) ? 5'd0 : v;
  endfunction

  function automatic logic [4:0] hour_to_12h(input logic [4:0] h);
    logic [4:0] r;
    if (h == 5'd0) begin
      r = 5'd12;
    end else if (h > 5'd12) begin
      r = h - 5'd12;
    end else begin
      r = h;
    end
    return r;
  endfunction

endpackage

// File: rtl/tod_bin2bcd.sv
// Binary (0..63) to packed two-digit BCD {tens, units}; purely combinational,
// the instantiating block registers the result.
module tod_bin2bcd
  import tod_pkg::*;
(
  input  logic [5:0] bin,
  output logic [7:0] bcd
);

  bcd_digit_t tens_s;
  bcd_digit_t units_s;

  // Constant divide/modulo by ten over a 6-bit range reduces to small logic.
  always_comb begin
    tens_s  = 4'(bin / 6'd10);
    units_s = 4'(bin % 6'd10);
  end

  assign bcd = {tens_s, units_s};

endmodule

// File: rtl/tod_clock_core.sv
// Time-of-day clock: prescaled 1 Hz tick, 24-hour binary counters, load/alarm
// handling with a ringing FSM, and registered BCD display with 12/24-hour mode.
module tod_clock_core
  import tod_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int ALARM_SECS = 30
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       mode12,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  input  logic       alarm_stop,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic       tick,
  output logic       alarm
);

  localparam int               CNT_W      = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_HZ - 1);
  localparam logic [7:0]       RING_LEN   = 8'(ALARM_SECS);

  logic [CNT_W-1:0] presc_r;
  logic [CNT_W-1:0] presc_nxt_s;
  logic             tick_r;

  logic [4:0] hour_r;
  logic [5:0] min_r;
  logic [5:0] sec_r;
  logic [4:0] hour_inc_s;
  logic [5:0] min_inc_s;
  logic [5:0] sec_inc_s;
  logic       inc_s;

  logic [4:0] alarm_hour_r;
  logic [5:0] alarm_min_r;
  logic       ring_match_s;

  alarm_state_t state_r;
  logic [7:0]   ring_cnt_r;
  logic         alarm_r;

  logic [4:0] hour_disp_s;
  logic [7:0] hour_bcd_s;
  logic [7:0] min_bcd_s;
  logic [7:0] sec_bcd_s;
  logic [7:0] hour_bcd_r;
  logic [7:0] min_bcd_r;
  logic [7:0] sec_bcd_r;
  logic       pm_r;

  // Next prescaler value; a load restarts the second from zero.
  always_comb begin
    presc_nxt_s = presc_r;
    if (load) begin
      presc_nxt_s = '0;
    end else if (presc_r == PRESC_LAST) begin
      presc_nxt_s = '0;
    end else begin
      presc_nxt_s = presc_r + CNT_W'(1);
    end
  end

  // Prescaler and registered tick, high exactly while the prescaler sits at its last count.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      presc_r <= presc_nxt_s;
      tick_r  <= (presc_nxt_s == PRESC_LAST);
    end
  end

  // One-second increment with same-cycle carries through min and hour.
  always_comb begin
    sec_inc_s  = sec_r;
    min_inc_s  = min_r;
    hour_inc_s = hour_r;
    if (sec_r == SEC_MAX) begin
      sec_inc_s = 6'd0;
      if (min_r == MIN_MAX) begin
        min_inc_s = 6'd0;
        if (hour_r == HOUR_MAX) begin
          hour_inc_s = 5'd0;
        end else begin
          hour_inc_s = hour_r + 5'd1;
        end
      end else begin
        min_inc_s = min_r + 6'd1;
      end
    end else begin
      sec_inc_s = sec_r + 6'd1;
    end
  end

  assign inc_s        = tick_r && !load;
  assign ring_match_s = inc_s && alarm_en && (hour_inc_s == alarm_hour_r)
                        && (min_inc_s == alarm_min_r) && (sec_inc_s == 6'd0);

  // Time and alarm-setting registers; load takes precedence over a pending increment.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hour_r       <= 5'd0;
      min_r        <= 6'd0;
      sec_r        <= 6'd0;
      alarm_hour_r <= 5'd0;
      alarm_min_r  <= 6'd0;
    end else begin
      if (load) begin
        hour_r <= clamp_hour(load_hour);
        min_r  <= clamp_min_sec(load_min);
        sec_r  <= clamp_min_sec(load_sec);
      end else if (tick_r) begin
        hour_r <= hour_inc_s;
        min_r  <= min_inc_s;
        sec_r  <= sec_inc_s;
      end
      if (alarm_set) begin
        alarm_hour_r <= clamp_hour(alarm_hour);
        alarm_min_r  <= clamp_min_sec(alarm_min);
      end
    end
  end

  // Alarm FSM: silencing beats a fresh match, and a match while ringing restarts the count.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r    <= ALARM_IDLE;
      ring_cnt_r <= 8'd0;
      alarm_r    <= 1'b0;
    end else if (alarm_stop || !alarm_en) begin
      state_r    <= ALARM_IDLE;
      ring_cnt_r <= 8'd0;
      alarm_r    <= 1'b0;
    end else if (ring_match_s) begin
      state_r    <= ALARM_RINGING;
      ring_cnt_r <= RING_LEN;
      alarm_r    <= 1'b1;
    end else begin
      case (state_r)
        ALARM_IDLE: begin
          state_r    <= ALARM_IDLE;
          ring_cnt_r <= 8'd0;
          alarm_r    <= 1'b0;
        end
        ALARM_RINGING: begin
          if (tick_r) begin
            if (ring_cnt_r <= 8'd1) begin
              state_r    <= ALARM_IDLE;
              ring_cnt_r <= 8'd0;
              alarm_r    <= 1'b0;
            end else begin
              ring_cnt_r <= ring_cnt_r - 8'd1;
            end
          end
        end
        default: begin
          state_r    <= ALARM_IDLE;
          ring_cnt_r <= 8'd0;
          alarm_r    <= 1'b0;
        end
      endcase
    end
  end

  assign hour_disp_s = mode12 ? hour_to_12h(hour_r) : hour_r;

  tod_bin2bcd u_hour_bcd (.bin({1'b0, hour_disp_s}), .bcd(hour_bcd_s));
  tod_bin2bcd u_min_bcd  (.bin(min_r),               .bcd(min_bcd_s));
  tod_bin2bcd u_sec_bcd  (.bin(sec_r),               .bcd(sec_bcd_s));

  // Display registers trail the time counters by one cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hour_bcd_r <= 8'h00;
      min_bcd_r  <= 8'h00;
      sec_bcd_r  <= 8'h00;
      pm_r       <= 1'b0;
    end else begin
      hour_bcd_r <= hour_bcd_s;
      min_bcd_r  <= min_bcd_s;
      sec_bcd_r  <= sec_bcd_s;
      pm_r       <= (hour_r >= 5'd12);
    end
  end

  assign hour_bcd = hour_bcd_r;
  assign min_bcd  = min_bcd_r;
  assign sec_bcd  = sec_bcd_r;
  assign pm       = pm_r;
  assign tick     = tick_r;
  assign alarm    = alarm_r;

endmodule

// File: tb/tb_tod_clock_core.sv
// Directed self-checking bench for tod_clock_core with CLK_HZ=4, ALARM_SECS=3.
module tb_tod_clock_core;

  logic       CLOCK_50;
  logic       reset;
  logic       load;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       mode12;
  logic       alarm_set;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       alarm_stop;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       pm;
  logic       tick;
  logic       alarm;

  int n_cmp = 0;
  int n_err = 0;

  tod_clock_core #(.CLK_HZ(4), .ALARM_SECS(3)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .load      (load),
    .load_hour (load_hour),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .mode12    (mode12),
    .alarm_set (alarm_set),
    .alarm_hour(alarm_hour),
    .alarm_min (alarm_min),
    .alarm_en  (alarm_en),
    .alarm_stop(alarm_stop),
    .hour_bcd  (hour_bcd),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .pm        (pm),
    .tick      (tick),
    .alarm     (alarm)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Returns 1 ns after the edge that performs the load.
  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    load_hour = h;
    load_min  = m;
    load_sec  = s;
    load      = 1'b1;
    step(1);
    load      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_hour = 5'd0; load_min = 6'd0; load_sec = 6'd0;
    mode12 = 1'b0; alarm_set = 1'b0; alarm_hour = 5'd0; alarm_min = 6'd0;
    alarm_en = 1'b0; alarm_stop = 1'b0;

    step(2);
    check_eq("rst_hour", hour_bcd, 8'h00);
    check_eq("rst_min", min_bcd, 8'h00);
    check_eq("rst_sec", sec_bcd, 8'h00);
    check_eq("rst_pm", pm, 1'b0);
    check_eq("rst_tick", tick, 1'b0);
    check_eq("rst_alarm", alarm, 1'b0);

    // Prescaler cadence after reset release.
    reset = 1'b0;
    step(1); check_eq("tick_e1", tick, 1'b0);
    step(1); check_eq("tick_e2", tick, 1'b0);
    step(1); check_eq("tick_e3", tick, 1'b1);
    step(1); check_eq("tick_e4", tick, 1'b0);
    check_eq("sec_e4", sec_bcd, 8'h00);
    step(1); check_eq("sec_e5", sec_bcd, 8'h01);
    step(2); check_eq("tick_e7", tick, 1'b1);

    // Midnight rollover.
    do_load(5'd23, 6'd59, 6'd59);
    step(1);
    check_eq("ld_hour", hour_bcd, 8'h23);
    check_eq("ld_min", min_bcd, 8'h59);
    check_eq("ld_sec", sec_bcd, 8'h59);
    check_eq("ld_pm", pm, 1'b1);
    step(4);
    check_eq("roll_hour", hour_bcd, 8'h00);
    check_eq("roll_min", min_bcd, 8'h00);
    check_eq("roll_sec", sec_bcd, 8'h00);
    check_eq("roll_pm", pm, 1'b0);

    // Clamped load and prescaler restart.
    do_load(5'd25, 6'd61, 6'd30);
    step(1);
    check_eq("clamp_hour", hour_bcd, 8'h00);
    check_eq("clamp_min", min_bcd, 8'h00);
    check_eq("clamp_sec", sec_bcd, 8'h30);
    step(1); check_eq("restart_e2", tick, 1'b0);
    step(1); check_eq("restart_e3", tick, 1'b1);
    step(2); check_eq("clamp_sec_inc", sec_bcd, 8'h31);

    // 12-hour display mapping.
    mode12 = 1'b1;
    do_load(5'd0, 6'd0, 6'd0);
    step(1);
    check_eq("m12_midnight", hour_bcd, 8'h12);
    check_eq("m12_midnight_pm", pm, 1'b0);
    do_load(5'd13, 6'd5, 6'd0);
    step(1);
    check_eq("m12_13h", hour_bcd, 8'h01);
    check_eq("m12_13h_pm", pm, 1'b1);
    check_eq("m12_13h_min", min_bcd, 8'h05);
    mode12 = 1'b0;
    step(1);
    check_eq("m24_13h", hour_bcd, 8'h13);

    // Alarm ring for three ticks.
    alarm_hour = 5'd7; alarm_min = 6'd0; alarm_en = 1'b1; alarm_set = 1'b1;
    step(1);
    alarm_set = 1'b0;
    check_eq("aset_no_ring", alarm, 1'b0);
    do_load(5'd6, 6'd59, 6'd59);
    step(3); check_eq("ring_pre", alarm, 1'b0);
    step(1); check_eq("ring_start", alarm, 1'b1);
    step(1); check_eq("ring_hour", hour_bcd, 8'h07);
    step(10); check_eq("ring_hold", alarm, 1'b1);
    step(1); check_eq("ring_expire", alarm, 1'b0);

    // alarm_stop and alarm_en early clears.
    do_load(5'd6, 6'd59, 6'd59);
    step(4); check_eq("stop_ring", alarm, 1'b1);
    alarm_stop = 1'b1;
    step(1);
    alarm_stop = 1'b0;
    check_eq("stop_clear", alarm, 1'b0);
    do_load(5'd6, 6'd59, 6'd59);
    step(4); check_eq("en_ring", alarm, 1'b1);
    alarm_en = 1'b0;
    step(1);
    check_eq("en_clear", alarm, 1'b0);
    alarm_en = 1'b1;

    // Load-triggered match must not ring.
    do_load(5'd7, 6'd0, 6'd0);
    step(1); check_eq("load_match", alarm, 1'b0);
    step(3); check_eq("load_match_inc", alarm, 1'b0);

    // Asynchronous reset while ringing.
    do_load(5'd6, 6'd59, 6'd59);
    step(4); check_eq("rst_ring_pre", alarm, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_ring_alarm", alarm, 1'b0);
    check_eq("rst_ring_hour", hour_bcd, 8'h00);
    check_eq("rst_ring_tick", tick, 1'b0);
    step(1);
    reset = 1'b0;
    step(2); check_eq("resume_e2", tick, 1'b0);
    step(1); check_eq("resume_e3", tick, 1'b1);
    step(2); check_eq("resume_sec", sec_bcd, 8'h01);
    check_eq("resume_alarm", alarm, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
